alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 en  input  1  stage enable (memory hit); pipeline register loads only when en=1 and busy=0.
REQ-004 flush  input  1  branch/jump taken; bubble inserted into M-stage register on an advancing edge.
REQ-005 src_a, src_b  input  32  forwarded ALU operands.
REQ-006 alu_ctrl  input  3  ALU operation select.
REQ-007 pc_e, imm_e  input  32  E-stage PC and sign-extended immediate.
REQ-008 write_data_e  input  32  store data; write_reg_e  input  5  destination register.
REQ-009 busy  output  1  multi-cycle operation in progress; stalls the whole pipeline.
REQ-010 alu_out_m, branch_target_m, write_data_m, pc_m  output  32  registered M-stage values.
REQ-011 zero_m  output  1 registered zero flag; write_reg_m  output  5  registered destination.

Function
REQ-012 alu_ctrl 000 AND, 001 OR, 010 ADD, 011 MUL (low 32 bits), 100 XOR, 101 SLL by src_b[4:0], 110 SUB, 111 SLT (signed, result 0 or 1).
REQ-013 Arithmetic wraps modulo 2^32; no overflow flag.
REQ-014 All ops except MUL are combinational, result available in the same cycle, busy=0.
REQ-015 MUL: busy asserted combinationally in the first cycle alu_ctrl=011 is present and stays high for 4 cycles; in the 5th cycle busy=0 and the product is presented on the result.
REQ-016 An internal done flag, set when MUL completes, prevents restart; cleared on every advancing edge (en=1, busy=0).
REQ-017 en=0 during MUL does not pause the counter; the completed product is held until the stage advances.
REQ-018 Zero flag = (ALU result == 32'h0), captured into zero_m.
REQ-019 Branch target = pc_e + imm_e (unshifted, byte offset), captured into branch_target_m.
REQ-020 Advancing edge, flush=0: register loads result, zero, target, write_data_e, write_reg_e, pc_e.
REQ-021 Advancing edge, flush=1: all M-stage outputs load 0 (bubble; write_reg_m=0 addresses x0).
REQ-022 Non-advancing edge (en=0 or busy=1): all M-stage outputs hold; flush ignored.

Reset
REQ-023 reset=1 immediately clears all M-stage outputs to 0, MUL counter to 0, done flag to 0; busy=0 unless a MUL is presented.
REQ-024 Reset asserted mid-MUL aborts it; after release the MUL restarts from cycle 1 if still presented.

Configuration
REQ-025 Macro ALU_EXEC_MUL_EN defined: MUL implemented per REQ-015..017.
REQ-026 ALU_EXEC_MUL_EN undefined: op 011 yields 0, busy tied to 0, counter and done flag omitted.

Structure
REQ-027 Shared package holds the 3-bit ALU opcode constants, MUL latency constant (5), and data/register widths (32, 5).
REQ-028 One sub-module alu_exec_alu (combinational ops plus MUL sequencer); target adder and pipeline register live in the top.

Verification
REQ-029 src_a=5, src_b=7, ADD, en=1 -> next edge alu_out_m=12, zero_m=0, busy=0.
REQ-030 src_a=3, src_b=3, SUB -> alu_out_m=0, zero_m=1; SLT src_a=-1, src_b=1 -> alu_out_m=1.
REQ-031 MUL 6x7, en=1 -> busy high 4 cycles, outputs hold, 5th-cycle edge gives alu_out_m=42, busy low.
REQ-032 pc_e=0x100, imm_e=0xFFFFFFF8, flush=0 -> branch_target_m=0xF8, pc_m=0x100.
REQ-033 flush=1, en=1 -> all outputs 0; flush=1, en=0 -> outputs unchanged.
REQ-034 reset pulse during MUL cycle 2 -> outputs 0 immediately; after release busy reasserts for full 4 cycles.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the E-stage ALU and its M-stage pipeline register.
package alu_exec_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int MUL_LAT = 5;
  localparam int CNT_W   = $clog2(MUL_LAT);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } aluOp_t;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    word_t             aluOut;
    logic              zero;
    word_t             branchTarget;
    word_t             writeData;
    word_t             pc;
    logic [REG_W-1:0]  writeReg;
  } mStage_t;

endpackage

// File: rtl/alu_exec_if.sv
// E-stage inputs and M-stage outputs of alu_exec, bundled as one interface.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic             en;
  logic             flush;
  word_t            src_a;
  word_t            src_b;
  logic [2:0]       alu_ctrl;
  word_t            pc_e;
  word_t            imm_e;
  word_t            write_data_e;
  logic [REG_W-1:0] write_reg_e;

  logic             busy;
  word_t            alu_out_m;
  word_t            branch_target_m;
  word_t            write_data_m;
  word_t            pc_m;
  logic             zero_m;
  logic [REG_W-1:0] write_reg_m;

  modport master (
    output en, flush, src_a, src_b, alu_ctrl, pc_e, imm_e, write_data_e, write_reg_e,
    input  busy, alu_out_m, branch_target_m, write_data_m, pc_m, zero_m, write_reg_m
  );

  modport slave (
    input  en, flush, src_a, src_b, alu_ctrl, pc_e, imm_e, write_data_e, write_reg_e,
    output busy, alu_out_m, branch_target_m, write_data_m, pc_m, zero_m, write_reg_m
  );

endinterface

// File: rtl/alu_exec_alu.sv
// ALU datapath plus multi-cycle MUL sequencer.
// MUL is implemented only when ALU_EXEC_MUL_EN is defined; otherwise op 011 returns 0.
module alu_exec_alu
  import alu_exec_pkg::*;
(
`ifdef ALU_EXEC_MUL_EN
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
`endif
  input  word_t  srcA,
  input  word_t  srcB,
  input  aluOp_t aluCtrl,
  output word_t  result,
  output logic   busy
);

  word_t mulResult;

`ifdef ALU_EXEC_MUL_EN
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             mulOp;
  logic             mulLast;
  logic             advance;

  assign mulOp     = (aluCtrl == OP_MUL);
  assign mulLast   = (cnt == CNT_W'(MUL_LAT - 1));
  assign busy      = mulOp && !done && !mulLast;
  assign advance   = en && !busy;
  assign mulResult = srcA * srcB;

  // The counter runs regardless of en; done parks a finished MUL until the stage advances.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (advance) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (mulOp && !done) begin
      if (mulLast) begin
        done <= 1'b1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (!mulOp) begin
      cnt <= '0;
    end
  end
`else
  assign busy      = 1'b0;
  assign mulResult = '0;
`endif

  // NOTE: result gets a default first so no path through the case can infer a latch.
  always_comb begin
    result = '0;
    case (aluCtrl)
      OP_AND: result = srcA & srcB;
      OP_OR:  result = srcA | srcB;
      OP_ADD: result = srcA + srcB;
      OP_MUL: result = mulResult;
      OP_XOR: result = srcA ^ srcB;
      OP_SLL: result = srcA << srcB[4:0];
      OP_SUB: result = srcA - srcB;
      OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: ALU, branch-target adder and E->M pipeline register.
// Optional multi-cycle MUL enabled with ALU_EXEC_MUL_EN.
module alu_exec
  import alu_exec_pkg::*;
(
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);

  word_t   aluResult;
  logic    busy;
  logic    advance;
  mStage_t mReg;
  mStage_t mNext;

  alu_exec_alu uAlu (
`ifdef ALU_EXEC_MUL_EN
    .clk     (clk),
    .reset   (reset),
    .en      (bus.en),
`endif
    .srcA    (bus.src_a),
    .srcB    (bus.src_b),
    .aluCtrl (aluOp_t'(bus.alu_ctrl)),
    .result  (aluResult),
    .busy    (busy)
  );

  assign advance = bus.en && !busy;

  // A flush loads an all-zero bubble, which also targets x0.
  always_comb begin
    mNext = '0;
    if (!bus.flush) begin
      mNext = '{
        aluOut:       aluResult,
        zero:         (aluResult == '0),
        branchTarget: bus.pc_e + bus.imm_e,
        writeData:    bus.write_data_e,
        pc:           bus.pc_e,
        writeReg:     bus.write_reg_e
      };
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mReg <= '0;
    end else if (advance) begin
      mReg <= mNext;
    end
  end

  assign bus.busy            = busy;
  assign bus.alu_out_m       = mReg.aluOut;
  assign bus.zero_m          = mReg.zero;
  assign bus.branch_target_m = mReg.branchTarget;
  assign bus.write_data_m    = mReg.writeData;
  assign bus.pc_m            = mReg.pc;
  assign bus.write_reg_m     = mReg.writeReg;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: spec-level model checked every cycle plus directed literals.
// Adapts its MUL expectations to whether ALU_EXEC_MUL_EN is defined.
module tb_alu_exec;
  import alu_exec_pkg::*;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic checkOn = 1'b0;
  int   passCnt = 0;
  int   totalCnt = 0;

  always #5 clk = ~clk;

  alu_exec_if bus ();

  alu_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] aluOut;
    logic        zero;
    logic [31:0] target;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  wreg;
  } expM_t;

  expM_t expM;
  int    mulAge;   // edges the currently presented MUL has been in flight
  logic  busyExp;

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return MUL_ON ? a * b : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign busyExp = MUL_ON && (bus.alu_ctrl == 3'b011) && (mulAge < 4);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      expM   <= '{default: '0};
      mulAge <= 0;
    end else if (bus.en && !busyExp) begin
      mulAge <= 0;
      if (bus.flush) expM <= '{default: '0};
      else expM <= '{
        aluOut: refAlu(bus.alu_ctrl, bus.src_a, bus.src_b),
        zero:   (refAlu(bus.alu_ctrl, bus.src_a, bus.src_b) == 32'd0),
        target: bus.pc_e + bus.imm_e,
        wdata:  bus.write_data_e,
        pc:     bus.pc_e,
        wreg:   bus.write_reg_e
      };
    end else if (bus.alu_ctrl == 3'b011) begin
      mulAge <= mulAge + 1;
    end else begin
      mulAge <= 0;
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      check("busy",            bus.busy,            busyExp);
      check("alu_out_m",       bus.alu_out_m,       expM.aluOut);
      check("zero_m",          bus.zero_m,          expM.zero);
      check("branch_target_m", bus.branch_target_m, expM.target);
      check("write_data_m",    bus.write_data_m,    expM.wdata);
      check("pc_m",            bus.pc_m,            expM.pc);
      check("write_reg_m",     bus.write_reg_m,     expM.wreg);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic flush);
    bus.alu_ctrl = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.en       = en;
    bus.flush    = flush;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [11];
  int   n;

  initial begin
    vecs = '{
      '{3'b010, 32'd5,          32'd7,          32'd12},
      '{3'b110, 32'd3,          32'd3,          32'd0},
      '{3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1},
      '{3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0},
      '{3'b000, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000},
      '{3'b001, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'hFFF0_FFF0},
      '{3'b100, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'hFF00_0FF0},
      '{3'b101, 32'd1,          32'h0000_0024,  32'h0000_0010},
      '{3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0},
      '{3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF},
      '{3'b101, 32'h8000_0001,  32'd31,         32'h8000_0000}
    };

    reset = 1'b1;
    drive(3'b010, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.pc_e = '0; bus.imm_e = '0; bus.write_data_e = '0; bus.write_reg_e = '0;
    #1 checkOn = 1'b1;
    #1;
    check("reset alu_out_m", bus.alu_out_m, 32'd0);
    check("reset write_reg_m", bus.write_reg_m, 32'd0);
    check("reset busy", bus.busy, 32'd0);
    #5 reset = 1'b0;
    tick();

    // Directed ALU vectors; the first also carries the branch-target example.
    bus.pc_e = 32'h100; bus.imm_e = 32'hFFFF_FFF8; bus.write_data_e = 32'hDEAD_BEEF; bus.write_reg_e = 5'd3;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      tick();
      check($sformatf("vec%0d alu_out_m", i), bus.alu_out_m, vecs[i].r);
      check($sformatf("vec%0d zero_m", i), bus.zero_m, (vecs[i].r == 32'd0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d busy", i), bus.busy, 32'd0);
    end
    check("branch_target_m", bus.branch_target_m, 32'h0000_00F8);
    check("pc_m", bus.pc_m, 32'h100);
    check("write_data_m", bus.write_data_m, 32'hDEAD_BEEF);
    check("write_reg_m", bus.write_reg_m, 32'd3);

    // Flush: ignored on a stalled edge, bubble on an advancing edge.
    bus.pc_e = 32'h200; bus.imm_e = 32'd4; bus.write_reg_e = 5'd7;
    drive(3'b010, 32'h10, 32'h20, 1'b1, 1'b0);
    tick();
    check("pre-flush alu_out_m", bus.alu_out_m, 32'h30);
    drive(3'b010, 32'd1, 32'd1, 1'b0, 1'b1);
    tick();
    check("flush en=0 alu_out_m", bus.alu_out_m, 32'h30);
    check("flush en=0 pc_m", bus.pc_m, 32'h200);
    drive(3'b010, 32'd1, 32'd1, 1'b1, 1'b1);
    tick();
    check("flush alu_out_m", bus.alu_out_m, 32'd0);
    check("flush pc_m", bus.pc_m, 32'd0);
    check("flush branch_target_m", bus.branch_target_m, 32'd0);
    check("flush write_reg_m", bus.write_reg_m, 32'd0);
    check("flush zero_m", bus.zero_m, 32'd0);

    // MUL 6x7 with en held high.
    drive(3'b010, 32'd1, 32'd2, 1'b1, 1'b0);
    tick();
    drive(3'b011, 32'd6, 32'd7, 1'b1, 1'b0);
    #1;
    check("mul first-cycle busy", bus.busy, MUL_ON ? 32'd1 : 32'd0);
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      tick();
    end
    check("mul busy cycles", n, MUL_ON ? 32'd4 : 32'd0);
    check("mul hold alu_out_m", bus.alu_out_m, 32'd3);
    tick();
    drive(3'b010, 32'd0, 32'd0, 1'b0, 1'b0);
    check("mul alu_out_m", bus.alu_out_m, MUL_ON ? 32'd42 : 32'd0);

    // MUL 3x5 with en low: counter keeps running, product waits for the stage to advance.
    drive(3'b011, 32'd3, 32'd5, 1'b0, 1'b0);
    repeat (7) tick();
    check("mul en=0 busy", bus.busy, 32'd0);
    check("mul en=0 hold", bus.alu_out_m, MUL_ON ? 32'd42 : 32'd0);
    bus.en = 1'b1;
    tick();
    drive(3'b010, 32'h11, 32'h22, 1'b1, 1'b0);
    check("mul en=0 result", bus.alu_out_m, MUL_ON ? 32'd15 : 32'd0);

    // Reset pulse during MUL cycle 2.
    tick();
    drive(3'b011, 32'd6, 32'd7, 1'b1, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    check("mid-mul reset alu_out_m", bus.alu_out_m, 32'd0);
    check("mid-mul reset pc_m", bus.pc_m, 32'd0);
    check("mid-mul reset write_data_m", bus.write_data_m, 32'd0);
    #2 reset = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      tick();
    end
    check("post-reset busy cycles", n, MUL_ON ? 32'd4 : 32'd0);
    tick();
    drive(3'b010, 32'd0, 32'd0, 1'b1, 1'b0);
    check("post-reset mul alu_out_m", bus.alu_out_m, MUL_ON ? 32'd42 : 32'd0);
    repeat (3) tick();

    checkOn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
